// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle ARM-subset controller.
// Holds the main FSM state enum, datapath select encodings, instruction
// field layout for Instr[31:12], cmd/cond constants and the condition check.
package mc_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  // Instr[31:12] as seen by the controller; for memory ops s is the L bit.
  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic       imm;
    logic [3:0] cmd;
    logic       s;
    logic [3:0] rn;
    logic [3:0] rd;
  } instr_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Condition evaluation against {N,Z,C,V}; 1111 is undefined and never passes.
  function automatic logic cond_check(input logic [3:0] cond,
                                      input logic [FLAGS_W-1:0] flags);
    logic n, z, c, v, res;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_controller_mainfsm.sv
// mc_mainfsm: Moore main FSM of the multicycle controller.
// Ports: i_clk, i_reset (sync, active-high); decoded class inputs i_op,
// i_imm, i_load, i_dp_ok (implemented DP/CMP), i_no_wb (CMP); base controls
// o_pc_fetch, o_ir_write, o_adr_src, o_alu_src_a, o_alu_src_b, o_result_src;
// state strobes o_in_decode, o_in_exec, o_alu_exec, o_reg_wb, o_mem_wr,
// o_branch (the top gates the last three with the condition).
module mc_mainfsm
  import mc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_op,
  input  logic       i_imm,
  input  logic       i_load,
  input  logic       i_dp_ok,
  input  logic       i_no_wb,
  output logic       o_pc_fetch,
  output logic       o_ir_write,
  output logic       o_adr_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic       o_in_decode,
  output logic       o_in_exec,
  output logic       o_alu_exec,
  output logic       o_reg_wb,
  output logic       o_mem_wr,
  output logic       o_branch
);

  state_t r_state;
  state_t w_next;
  state_t w_state_eff;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= FETCH;
    else         r_state <= w_next;
  end

  // While reset is held the outputs present FETCH selects with enables off.
  assign w_state_eff = i_reset ? FETCH : r_state;

  // Next-state and Moore outputs.
  always_comb begin
    w_next       = FETCH;
    o_pc_fetch   = 1'b0;
    o_ir_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_WD;
    o_result_src = RES_ALUOUT;
    o_in_decode  = 1'b0;
    o_in_exec    = 1'b0;
    o_alu_exec   = 1'b0;
    o_reg_wb     = 1'b0;
    o_mem_wr     = 1'b0;
    o_branch     = 1'b0;
    case (w_state_eff)
      FETCH: begin
        o_ir_write   = ~i_reset;
        o_pc_fetch   = ~i_reset;
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURESULT;
        w_next       = DECODE;
      end
      DECODE: begin
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURESULT;
        o_in_decode  = 1'b1;
        case (i_op)
          OP_MEM:  w_next = MEMADR;
          OP_DP:   w_next = i_dp_ok ? (i_imm ? EXECUTEI : EXECUTER) : FETCH;
          OP_BR:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR: begin
        o_alu_src_b = SRCB_IMM;
        w_next      = i_load ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        o_adr_src = 1'b1;
        w_next    = MEMWB;
      end
      MEMWB: begin
        o_adr_src    = 1'b1;
        o_result_src = RES_DATA;
        o_reg_wb     = 1'b1;
      end
      MEMWRITE: begin
        o_adr_src = 1'b1;
        o_mem_wr  = 1'b1;
      end
      EXECUTER, EXECUTEI: begin
        o_alu_src_b = (w_state_eff == EXECUTEI) ? SRCB_IMM : SRCB_WD;
        o_alu_exec  = 1'b1;
        o_in_exec   = 1'b1;
        w_next      = i_no_wb ? FETCH : ALUWB;
      end
      ALUWB: begin
        o_result_src = RES_ALUOUT;
        o_reg_wb     = 1'b1;
      end
      BRANCH: begin
        o_alu_src_b  = SRCB_IMM;
        o_result_src = RES_ALURESULT;
        o_branch     = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the ARM-subset core.
// Decodes Instr[31:12], keeps the NZCV flags, latches the condition result
// in DECODE and gates the main FSM's write strobes with it.
// Ports: clk, reset (sync, active-high), Instr[19:0], ALUFlags[3:0] in;
// PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, RegSrc, ALUSrcA, ALUSrcB,
// ResultSrc, ImmSrc, ALUControl out.
// Build option: MC_CTRL_CMP_EN enables CMP (cmd 1010 with S=1).
module mc_controller
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [FLAGS_W-1:0] ALUFlags,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         RegSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ALUControl
);

  instr_t             w_ins;
  logic               w_cmd_add, w_cmd_sub, w_cmd_and, w_cmd_orr, w_cmd_cmp;
  logic               w_dp_ok;
  logic               w_cond_ex;
  logic               w_rd15;
  logic [1:0]         w_alu_dp;
  logic               w_pc_fetch, w_in_decode, w_in_exec, w_alu_exec;
  logic               w_reg_wb, w_mem_wr, w_branch;
  logic               w_unused_rn;
  logic [FLAGS_W-1:0] r_flags;
  logic               r_cond_q;

  assign w_ins       = instr_t'(Instr);
  assign w_unused_rn = ^w_ins.rn;

  // DP command decode; anything not listed leaves the instruction unimplemented.
  assign w_cmd_add = (w_ins.cmd == CMD_ADD);
  assign w_cmd_sub = (w_ins.cmd == CMD_SUB);
  assign w_cmd_and = (w_ins.cmd == CMD_AND);
  assign w_cmd_orr = (w_ins.cmd == CMD_ORR);
`ifdef MC_CTRL_CMP_EN
  assign w_cmd_cmp = (w_ins.cmd == CMD_CMP) & w_ins.s;
`else
  assign w_cmd_cmp = 1'b0;
`endif
  assign w_dp_ok = w_cmd_add | w_cmd_sub | w_cmd_and | w_cmd_orr | w_cmd_cmp;

  assign w_cond_ex = cond_check(w_ins.cond, r_flags);
  assign w_rd15    = (w_ins.rd == 4'hF);

  mc_mainfsm u_mainfsm (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_op         (w_ins.op),
    .i_imm        (w_ins.imm),
    .i_load       (w_ins.s),
    .i_dp_ok      (w_dp_ok),
    .i_no_wb      (w_cmd_cmp),
    .o_pc_fetch   (w_pc_fetch),
    .o_ir_write   (IRWrite),
    .o_adr_src    (AdrSrc),
    .o_alu_src_a  (ALUSrcA),
    .o_alu_src_b  (ALUSrcB),
    .o_result_src (ResultSrc),
    .o_in_decode  (w_in_decode),
    .o_in_exec    (w_in_exec),
    .o_alu_exec   (w_alu_exec),
    .o_reg_wb     (w_reg_wb),
    .o_mem_wr     (w_mem_wr),
    .o_branch     (w_branch)
  );

  // Condition latch and flags; N,Z follow any S-type op, C,V only arithmetic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags  <= '0;
      r_cond_q <= 1'b0;
    end else begin
      if (w_in_decode) r_cond_q <= w_cond_ex;
      if (w_in_exec && r_cond_q && w_ins.s) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (w_cmd_add || w_cmd_sub || w_cmd_cmp) r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // ALU operation for the execute states; CMP is a SUB without writeback.
  always_comb begin
    w_alu_dp = ALU_ADD;
    if (w_cmd_sub || w_cmd_cmp) w_alu_dp = ALU_SUB;
    else if (w_cmd_and)         w_alu_dp = ALU_AND;
    else if (w_cmd_orr)         w_alu_dp = ALU_ORR;
  end

  // Immediate format follows the instruction class of the held Instr.
  always_comb begin
    ImmSrc = IMM_8;
    case (w_ins.op)
      OP_MEM:  ImmSrc = IMM_12;
      OP_BR:   ImmSrc = IMM_24;
      default: ImmSrc = IMM_8;
    endcase
  end

  assign ALUControl = w_alu_exec ? w_alu_dp : ALU_ADD;
  assign RegSrc     = {(w_ins.op == OP_MEM) & ~w_ins.s, (w_ins.op == OP_BR)};

  // Writes to Rd=15 redirect the writeback into the PC as well.
  assign RegWrite = w_reg_wb & r_cond_q;
  assign MemWrite = w_mem_wr & r_cond_q;
  assign PCWrite  = w_pc_fetch | (w_branch & r_cond_q) | (w_reg_wb & r_cond_q & w_rd15);

endmodule
